// File: rtl/counter_bank_pkg.sv
// Shared types and limits for the counter bank: channel actions, counter modes, parameter ranges.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_bank_pkg;

    // Per-channel counting behaviour at the range bounds
    typedef enum logic {
        CNT_WRAP,
        CNT_SAT
    } cnt_mode_e;

    // What a channel does on the coming edge, already priority-resolved
    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_INC,
        ACT_DEC
    } cnt_act_e;

    // Legal parameter ranges
    localparam int NUM_CH_MIN = 1;
    localparam int NUM_CH_MAX = 32;
    localparam int WIDTH_MIN  = 2;
    localparam int WIDTH_MAX  = 32;

endpackage

// File: rtl/counter_bank_if.sv
// Signal bundle between a controller and the counter bank; names are from the bank's point of view.
// Latency: none (wires only). Optional i_sat member exists only with COUNTER_BANK_SAT_EN.
// Backpressure: none; the bank accepts every input on every cycle.
interface counter_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
);
    logic [NUM_CH-1:0]       i_en;
    logic [NUM_CH-1:0]       i_down;
    logic [NUM_CH-1:0]       i_load_en;
    logic [NUM_CH*WIDTH-1:0] i_load;
    logic [NUM_CH*WIDTH-1:0] i_limit;
`ifdef COUNTER_BANK_SAT_EN
    logic [NUM_CH-1:0]       i_sat;
`endif
    logic [NUM_CH-1:0]       i_clr_wrap;
    logic                    i_snap_req;
    logic [NUM_CH*WIDTH-1:0] o_count;
    logic [NUM_CH-1:0]       o_at_limit;
    logic [NUM_CH-1:0]       o_at_zero;
    logic [NUM_CH-1:0]       o_wrap_pulse;
    logic [NUM_CH-1:0]       o_wrap_sticky;
    logic [NUM_CH*WIDTH-1:0] o_snap_count;
    logic                    o_snap_valid;

    modport master (
`ifdef COUNTER_BANK_SAT_EN
        output i_sat,
`endif
        output i_en, i_down, i_load_en, i_load, i_limit, i_clr_wrap, i_snap_req,
        input  o_count, o_at_limit, o_at_zero, o_wrap_pulse, o_wrap_sticky,
        input  o_snap_count, o_snap_valid
    );

    modport slave (
`ifdef COUNTER_BANK_SAT_EN
        input  i_sat,
`endif
        input  i_en, i_down, i_load_en, i_load, i_limit, i_clr_wrap, i_snap_req,
        output o_count, o_at_limit, o_at_zero, o_wrap_pulse, o_wrap_sticky,
        output o_snap_count, o_snap_valid
    );

endinterface

// File: rtl/counter_bank_ch.sv
// One counter channel: modulo-limit up/down count with load, registered wrap pulse and sticky wrap flag.
// Latency: count/pulse/sticky 1 cycle after inputs; at_limit/at_zero combinational. Saturation with COUNTER_BANK_SAT_EN.
// Backpressure: none; an action is taken on every edge.
module counter_bank_ch
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_down,
    input  logic             i_load_en,
    input  logic [WIDTH-1:0] i_load,
    input  logic [WIDTH-1:0] i_limit,
`ifdef COUNTER_BANK_SAT_EN
    input  logic             i_sat,
`endif
    input  logic             i_clr_wrap,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_limit,
    output logic             o_at_zero,
    output logic             o_wrap_pulse,
    output logic             o_wrap_sticky
);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap_pulse;
    logic             r_wrap_sticky;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;
    cnt_act_e         w_act;
    cnt_mode_e        w_mode;

`ifdef COUNTER_BANK_SAT_EN
    assign w_mode = i_sat ? CNT_SAT : CNT_WRAP;
`else
    assign w_mode = CNT_WRAP;
`endif

    // Resolve the action: load beats count, count beats hold
    always_comb begin
        w_act = ACT_HOLD;
        if (i_load_en) begin
            w_act = ACT_LOAD;
        end else if (i_en) begin
            w_act = i_down ? ACT_DEC : ACT_INC;
        end
    end

    // Next count and wrap event; bounds are compared before any add/subtract so nothing overflows
    always_comb begin
        w_next = r_count;
        w_wrap = 1'b0;
        unique case (w_act)
            ACT_LOAD: begin
                w_next = (i_load > i_limit) ? i_limit : i_load;
            end
            ACT_INC: begin
                if (r_count >= i_limit) begin
                    if (w_mode == CNT_WRAP) begin
                        w_next = '0;
                        w_wrap = 1'b1;
                    end else begin
                        w_next = i_limit;
                    end
                end else begin
                    w_next = r_count + WIDTH'(1);
                end
            end
            ACT_DEC: begin
                if (r_count == '0) begin
                    if (w_mode == CNT_WRAP) begin
                        w_next = i_limit;
                        w_wrap = 1'b1;
                    end else begin
                        w_next = '0;
                    end
                end else if (r_count > i_limit) begin
                    // limit was lowered under a running count: snap down to it quietly
                    w_next = i_limit;
                end else begin
                    w_next = r_count - WIDTH'(1);
                end
            end
            default: begin
                w_next = r_count;
            end
        endcase
    end

    // Count register, wrap pulse, and sticky flag where a new wrap outranks a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count       <= '0;
            r_wrap_pulse  <= 1'b0;
            r_wrap_sticky <= 1'b0;
        end else begin
            r_count       <= w_next;
            r_wrap_pulse  <= w_wrap;
            r_wrap_sticky <= w_wrap | (r_wrap_sticky & ~i_clr_wrap);
        end
    end

    assign o_count       = r_count;
    assign o_at_limit    = (r_count == i_limit);
    assign o_at_zero     = (r_count == '0);
    assign o_wrap_pulse  = r_wrap_pulse;
    assign o_wrap_sticky = r_wrap_sticky;

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent up/down counters plus an atomic all-channel snapshot register.
// Latency: counts 1 cycle; snapshot valid 1 cycle after snap_req. Saturation option: COUNTER_BANK_SAT_EN.
// Backpressure: none; snapshot requests are captured every cycle they are asserted.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic         clk,
    input  logic         rst,
    counter_bank_if.slave bus
);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("counter_bank: NUM_CH out of range");
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("counter_bank: WIDTH out of range");
    end

    logic [NUM_CH*WIDTH-1:0] w_count;
    logic [NUM_CH-1:0]       w_at_limit;
    logic [NUM_CH-1:0]       w_at_zero;
    logic [NUM_CH-1:0]       w_wrap_pulse;
    logic [NUM_CH-1:0]       w_wrap_sticky;
    logic [NUM_CH*WIDTH-1:0] r_snap_count;
    logic                    r_snap_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        counter_bank_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .i_en          (bus.i_en[g]),
            .i_down        (bus.i_down[g]),
            .i_load_en     (bus.i_load_en[g]),
            .i_load        (bus.i_load[g*WIDTH +: WIDTH]),
            .i_limit       (bus.i_limit[g*WIDTH +: WIDTH]),
`ifdef COUNTER_BANK_SAT_EN
            .i_sat         (bus.i_sat[g]),
`endif
            .i_clr_wrap    (bus.i_clr_wrap[g]),
            .o_count       (w_count[g*WIDTH +: WIDTH]),
            .o_at_limit    (w_at_limit[g]),
            .o_at_zero     (w_at_zero[g]),
            .o_wrap_pulse  (w_wrap_pulse[g]),
            .o_wrap_sticky (w_wrap_sticky[g])
        );
    end

    // Capture the pre-edge counts of every channel together so the snapshot is coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_count <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= bus.i_snap_req;
            if (bus.i_snap_req) begin
                r_snap_count <= w_count;
            end
        end
    end

    assign bus.o_count       = w_count;
    assign bus.o_at_limit    = w_at_limit;
    assign bus.o_at_zero     = w_at_zero;
    assign bus.o_wrap_pulse  = w_wrap_pulse;
    assign bus.o_wrap_sticky = w_wrap_sticky;
    assign bus.o_snap_count  = r_snap_count;
    assign bus.o_snap_valid  = r_snap_valid;

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: table of channel-0 vectors plus snapshot, saturation and async-reset sequences.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_counter_bank;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int NV  = 27;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    counter_bank_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();

    counter_bank #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic       en;
        logic       dn;
        logic [7:0] load;
        logic [7:0] lim;
        logic       clr;
        logic [7:0] cnt;
        logic       pulse;
        logic       sticky;
    } vec_t;

    vec_t vecs [NV];
    vec_t v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //          ld    en    dn    load   lim    clr   cnt    pulse sticky
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd5,  1'b0, 8'd1,  1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd5,  1'b0, 8'd2,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd5,  1'b0, 8'd3,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd5,  1'b0, 8'd4,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd5,  1'b0, 8'd5,  1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd5,  1'b0, 8'd0,  1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd5,  1'b0, 8'd1,  1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd5,  1'b0, 8'd1,  1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd5,  1'b1, 8'd1,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'd9,  1'b0, 8'd0,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'd9,  1'b0, 8'd9,  1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd9,  1'b1, 8'd9,  1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd4,  8'd9,  1'b0, 8'd4,  1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 8'd200,8'd9,  1'b0, 8'd9,  1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'd3,  1'b0, 8'd3,  1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'd3,  1'b0, 8'd2,  1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h2A, 8'hFF, 1'b0, 8'h2A, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h2B, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'd0,  1'b0, 8'h00, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd0,  1'b0, 8'h00, 1'b1, 1'b1};
        vecs[25] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'd0,  1'b0, 8'h00, 1'b1, 1'b1};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0,  1'b1, 8'h00, 1'b0, 1'b0};

        // Reset state
        rst            = 1'b1;
        bus.i_en       = '0;
        bus.i_down     = '0;
        bus.i_load_en  = '0;
        bus.i_load     = '0;
        bus.i_limit    = {8'h10, 8'h10, 8'h10, 8'd5};
        bus.i_clr_wrap = '0;
        bus.i_snap_req = 1'b0;
`ifdef COUNTER_BANK_SAT_EN
        bus.i_sat      = '0;
`endif
        step();
        step();
        chk("rst_count", bus.o_count, 32'h0);
        chk("rst_pulse", 32'(bus.o_wrap_pulse), 32'h0);
        chk("rst_sticky", 32'(bus.o_wrap_sticky), 32'h0);
        chk("rst_snap_count", bus.o_snap_count, 32'h0);
        chk("rst_snap_valid", 32'(bus.o_snap_valid), 32'h0);
        chk("rst_at_zero", 32'(bus.o_at_zero), 32'hF);
        rst = 1'b0;

        // Channel-0 vector table; other channels idle and must stay at 0
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            bus.i_load_en  = {3'b000, v.ld};
            bus.i_en       = {3'b000, v.en};
            bus.i_down     = {3'b000, v.dn};
            bus.i_load     = {24'h0, v.load};
            bus.i_limit    = {8'h10, 8'h10, 8'h10, v.lim};
            bus.i_clr_wrap = {3'b000, v.clr};
            step();
            chk($sformatf("vec%0d_count", i), 32'(bus.o_count[7:0]), 32'(v.cnt));
            chk($sformatf("vec%0d_pulse", i), 32'(bus.o_wrap_pulse[0]), 32'(v.pulse));
            chk($sformatf("vec%0d_sticky", i), 32'(bus.o_wrap_sticky[0]), 32'(v.sticky));
            chk($sformatf("vec%0d_at_limit", i), 32'(bus.o_at_limit[0]), 32'(v.cnt == v.lim));
            chk($sformatf("vec%0d_at_zero", i), 32'(bus.o_at_zero[0]), 32'(v.cnt == 8'h00));
            chk($sformatf("vec%0d_others", i), 32'(bus.o_count[31:8]), 32'h0);
        end
        bus.i_load_en  = '0;
        bus.i_en       = '0;
        bus.i_down     = '0;
        bus.i_clr_wrap = '0;

`ifdef COUNTER_BANK_SAT_EN
        // Saturation: limit 3, count up from 0 then down at 0
        bus.i_sat       = 4'b0001;
        bus.i_limit     = {8'h10, 8'h10, 8'h10, 8'd3};
        bus.i_load_en   = 4'b0001;
        bus.i_load      = '0;
        step();
        bus.i_load_en   = '0;
        bus.i_en        = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("sat_up%0d_count", i), 32'(bus.o_count[7:0]), (i < 3) ? 32'(i + 1) : 32'd3);
            chk($sformatf("sat_up%0d_pulse", i), 32'(bus.o_wrap_pulse[0]), 32'h0);
        end
        chk("sat_up_sticky", 32'(bus.o_wrap_sticky[0]), 32'h0);
        bus.i_en      = '0;
        bus.i_load_en = 4'b0001;
        step();
        bus.i_load_en = '0;
        bus.i_en      = 4'b0001;
        bus.i_down    = 4'b0001;
        step();
        chk("sat_dn_count", 32'(bus.o_count[7:0]), 32'h0);
        chk("sat_dn_pulse", 32'(bus.o_wrap_pulse[0]), 32'h0);
        chk("sat_dn_sticky", 32'(bus.o_wrap_sticky[0]), 32'h0);
        bus.i_en   = '0;
        bus.i_down = '0;
        bus.i_sat  = '0;
`endif

        // Snapshot atomicity: four channels with different limits
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_limit = {8'd200, 8'd7, 8'd5, 8'd3};
        bus.i_en    = 4'hF;
        for (int i = 0; i < 10; i++) step();
        chk("snap_pre_count", bus.o_count, {8'd10, 8'd2, 8'd4, 8'd2});
        chk("snap_pre_valid", 32'(bus.o_snap_valid), 32'h0);
        bus.i_snap_req = 1'b1;
        step();
        chk("snap1_valid", 32'(bus.o_snap_valid), 32'h1);
        chk("snap1_count", bus.o_snap_count, {8'd10, 8'd2, 8'd4, 8'd2});
        chk("snap1_live", bus.o_count, {8'd11, 8'd3, 8'd5, 8'd3});
        step();
        chk("snap2_valid", 32'(bus.o_snap_valid), 32'h1);
        chk("snap2_count", bus.o_snap_count, {8'd11, 8'd3, 8'd5, 8'd3});
        chk("snap2_live", bus.o_count, {8'd12, 8'd4, 8'd0, 8'd0});
        chk("snap2_pulse", 32'(bus.o_wrap_pulse), 32'h3);
        bus.i_snap_req = 1'b0;
        step();
        chk("snap3_valid", 32'(bus.o_snap_valid), 32'h0);
        chk("snap3_hold", bus.o_snap_count, {8'd11, 8'd3, 8'd5, 8'd3});
        chk("snap3_live", bus.o_count, {8'd13, 8'd5, 8'd1, 8'd1});
        chk("snap3_pulse", 32'(bus.o_wrap_pulse), 32'h0);
        chk("snap3_sticky", 32'(bus.o_wrap_sticky), 32'h7);

        // Async reset between edges with a snapshot in flight
        bus.i_en       = '0;
        bus.i_limit    = {8'd200, 8'd7, 8'd5, 8'hFF};
        bus.i_load_en  = 4'b0001;
        bus.i_load     = {24'h0, 8'h37};
        bus.i_snap_req = 1'b1;
        step();
        chk("ar_pre_count", 32'(bus.o_count[7:0]), 32'h37);
        chk("ar_pre_valid", 32'(bus.o_snap_valid), 32'h1);
        chk("ar_pre_snap", bus.o_snap_count, {8'd13, 8'd5, 8'd1, 8'd1});
        #2;
        rst = 1'b1;
        #1;
        chk("ar_count", bus.o_count, 32'h0);
        chk("ar_sticky", 32'(bus.o_wrap_sticky), 32'h0);
        chk("ar_pulse", 32'(bus.o_wrap_pulse), 32'h0);
        chk("ar_snap_count", bus.o_snap_count, 32'h0);
        chk("ar_snap_valid", 32'(bus.o_snap_valid), 32'h0);
        bus.i_load_en  = '0;
        bus.i_snap_req = 1'b0;
        bus.i_en       = 4'b0001;
        bus.i_limit    = {8'd200, 8'd7, 8'd5, 8'd5};
        step();
        chk("ar_held_count", 32'(bus.o_count[7:0]), 32'h0);
        rst = 1'b0;
        step();
        chk("ar_first_count", 32'(bus.o_count[7:0]), 32'h1);
        bus.i_en = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised bank of NUM_CH independent up/down counters with a programmable per-channel terminal value, wrap detection and an atomic all-channel snapshot. It generalises the single fixed-width up/down counter with load and rollover. It sits beside the stimulus and timing logic as a shared event/interval counter resource. Per channel it adds a modulo limit, a registered wrap pulse, a sticky wrap flag and, optionally, saturation.

## Interface
Parameters:
- NUM_CH, 4: number of independent counter channels (1..32).
- WIDTH, 8: counter width in bits (2..32).

Ports (vectors are flattened; channel i occupies bits [i*WIDTH +: WIDTH] or bit [i]):
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- en  in  NUM_CH  count enable per channel.
- down  in  NUM_CH  1 = decrement, 0 = increment.
- load_en  in  NUM_CH  synchronous load strobe per channel.
- load  in  NUM_CH*WIDTH  load values.
- limit  in  NUM_CH*WIDTH  terminal (maximum) value per channel; count range is 0..limit.
- sat  in  NUM_CH  1 = saturate at bounds, 0 = wrap. Present only when COUNTER_BANK_SAT_EN is defined.
- clr_wrap  in  NUM_CH  clears the sticky wrap flag.
- snap_req  in  1  snapshot request.
- count  out  NUM_CH*WIDTH  live counter values, registered.
- at_limit  out  NUM_CH  combinational: count == limit.
- at_zero  out  NUM_CH  combinational: count == 0.
- wrap_pulse  out  NUM_CH  registered one-cycle pulse when a wrap occurs.
- wrap_sticky  out  NUM_CH  sticky wrap indicator.
- snap_count  out  NUM_CH*WIDTH  captured counter values.
- snap_valid  out  1  one-cycle pulse marking a new snapshot.

## Operation
- Reset values: count = 0, wrap_pulse = 0, wrap_sticky = 0, snap_count = 0, snap_valid = 0.
- Per-channel priority on each edge: load_en, then en, then hold.
- Load: count <= min(load, limit). A load never generates a wrap.
- Up count (en=1, down=0):
  - if count >= limit: count <= 0 and wrap (wrap mode);
  - otherwise count + 1.
- Down count (en=1, down=1):
  - if count == 0: count <= limit and wrap (wrap mode);
  - if count > limit, which is possible after limit is lowered: count <= limit, with no wrap;
  - otherwise count − 1.
- Saturate mode (sat=1):
  - up at count >= limit holds count at limit;
  - down at 0 holds 0;
  - no wrap is generated.
- limit = 0: count stays at 0. Each enabled cycle in wrap mode generates a wrap.
- All arithmetic is WIDTH bits. The +1 comparison happens before the add, so a natural 2^WIDTH overflow never occurs when limit = all-ones.
- wrap_pulse[i] is asserted in the cycle the wrapped count value is visible on count.
- wrap_sticky[i] is set by a wrap and cleared by clr_wrap[i]. If both occur in the same cycle, set wins.
- Snapshot:
  - snap_req sampled high captures all NUM_CH count values present before that edge's update into snap_count;
  - snap_valid pulses in the following cycle;
  - back-to-back requests capture every cycle.
- Channels are fully independent. There is no cross-channel carry.

## Timing
- count, wrap_pulse and wrap_sticky update one clock after their inputs are sampled, with zero extra latency.
- at_limit and at_zero are combinational from count and limit, so they have the same-cycle relation to count.
- snap_count and snap_valid appear one cycle after snap_req.
- Asserting rst mid-operation clears everything asynchronously, including a snapshot in flight. The first count update occurs on the first posedge after rst deasserts.

## Configuration
- Macro: COUNTER_BANK_SAT_EN.
- Defined: the sat port exists and per-channel saturation is selectable as described above.
- Undefined: the sat port is absent and every channel always wraps. The saturation logic is not synthesised.

## Structure
- Package counter_bank_pkg holds:
  - a counter-mode enum {CNT_WRAP, CNT_SAT};
  - an action enum {ACT_HOLD, ACT_LOAD, ACT_INC, ACT_DEC};
  - WIDTH/NUM_CH range-check constants.
- Sub-module counter_bank_ch implements one channel: count register, wrap pulse and sticky flag.
- The top generates NUM_CH instances of counter_bank_ch and owns the snapshot register and snap_valid.

## Test plan
- Reset and wrap: assert rst, then release with WIDTH=8, limit=5, up count for 7 cycles → count 1,2,3,4,5,0,1; wrap_pulse high exactly with count=0; wrap_sticky stays 1 until clr_wrap.
- Down wrap and lowered limit:
  - down from 0 with limit=9 → count 9 and wrap_pulse;
  - load 200 with limit=9 → count 9;
  - with count=9, lower limit to 3 and count down → count 3 with no wrap.
- Saturation (COUNTER_BANK_SAT_EN): sat=1, limit=3, up 6 cycles → count 1,2,3,3,3,3 with no wrap; down from 0 holds 0.
- Load priority and sticky clear:
  - load_en and en both high with load=0x2A → count 0x2A;
  - wrap together with clr_wrap in the same cycle → wrap_sticky stays 1.
- Snapshot atomicity: 4 channels counting with different limits; pulse snap_req at cycle 10 → next cycle snap_valid=1 and snap_count equals the pre-edge counts of all channels.
- Async reset mid-count: assert rst between edges with count=0x37 → count, sticky and snap outputs read 0 immediately, before the next posedge.
